// File: rtl/atto_pkg.sv
// Shared link constants and packet layout for the router output stage.
package atto_pkg;

    localparam int unsigned PKT_W    = 48;
    localparam int unsigned DX_HI    = 47;
    localparam int unsigned DX_LO    = 44;
    localparam int unsigned DY_HI    = 43;
    localparam int unsigned DY_LO    = 40;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned PAYLD_W  = 40;
    localparam int unsigned CREDIT_W = 4;

    localparam logic [1:0] LINK_VALID = 2'b10;
    localparam logic [1:0] LINK_IDLE  = 2'b00;

    // Packet as carried on the crossbar and the link.
    typedef struct packed {
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [PAYLD_W-1:0] payload;
    } pkt_t;

endpackage

// File: rtl/output_flow_handler.sv
// Credit counter, launch decision and link strobe register for the outport.
module output_flow_handler
    import atto_pkg::*;
#(
    parameter int unsigned CREDITS = 4
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic                fifo_empty,
    input  logic                credit_din,
    output logic                launch_en,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic [1:0]          diff_pair_dout
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);

    // Launch whenever a packet is waiting and the neighbour has a free slot.
    always_comb begin
        launch_en = !fifo_empty && (credit_cnt != '0);
    end

    // Credit counter: a returned credit and a launch in the same cycle cancel.
    always_ff @(posedge clka) begin
        if (rsta) begin
            credit_cnt <= CREDIT_MAX;
        end else begin
            case ({credit_din, launch_en})
                2'b10: if (credit_cnt != CREDIT_MAX) credit_cnt <= credit_cnt + CREDIT_W'(1);
                2'b01: credit_cnt <= credit_cnt - CREDIT_W'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Strobe marks the cycle in which the channel carries a fresh packet.
    always_ff @(posedge clka) begin
        if (rsta) begin
            diff_pair_dout <= LINK_IDLE;
        end else begin
            diff_pair_dout <= launch_en ? LINK_VALID : LINK_IDLE;
        end
    end

endmodule

// File: rtl/outport.sv
// Router output stage: 2-entry FIFO feeding a credit-controlled 48-bit link.
// Optional sticky error checks are built when OUTPORT_ERR_CHECK_EN is defined.
module outport
    import atto_pkg::*;
#(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned X_LOCAL = 2,
    parameter int unsigned Y_LOCAL = 2
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             valid_din,
    input  logic [PKT_W-1:0] packet_din,
    output logic             ready_dout,
    input  logic             credit_din,
    output logic [1:0]       diff_pair_dout,
    output logic [PKT_W-1:0] channel_dout,
    output logic [2:0]       error_dout
);

    logic [PKT_W-1:0]    fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_cnt;
    logic                fifo_empty;
    logic                wr_en;
    logic                launch_en;
    logic [CREDIT_W-1:0] credit_cnt;

    // Acceptance depends only on FIFO occupancy and reset, never on valid_din.
    always_comb begin
        ready_dout = (fifo_cnt < 2'd2) && !rsta;
        wr_en      = valid_din && ready_dout;
        fifo_empty = (fifo_cnt == 2'd0);
    end

    // FIFO storage; stale contents are harmless because pointers are reset.
    always_ff @(posedge clka) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= packet_din;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clka) begin
        if (rsta) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (wr_en)     wr_ptr <= ~wr_ptr;
            if (launch_en) rd_ptr <= ~rd_ptr;
            case ({wr_en, launch_en})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Channel register holds the last launched packet between launches.
    always_ff @(posedge clka) begin
        if (rsta) begin
            channel_dout <= '0;
        end else if (launch_en) begin
            channel_dout <= fifo_mem[rd_ptr];
        end
    end

    output_flow_handler #(
        .CREDITS (CREDITS)
    ) u_flow (
        .clka           (clka),
        .rsta           (rsta),
        .fifo_empty     (fifo_empty),
        .credit_din     (credit_din),
        .launch_en      (launch_en),
        .credit_cnt     (credit_cnt),
        .diff_pair_dout (diff_pair_dout)
    );

`ifdef OUTPORT_ERR_CHECK_EN
    pkt_t in_pkt;
    logic credit_ovf;
    logic pkt_drop;
    logic pkt_uturn;

    // Error conditions; a U-turn packet is one addressed to this router.
    always_comb begin
        in_pkt     = pkt_t'(packet_din);
        credit_ovf = credit_din && (credit_cnt == CREDIT_W'(CREDITS)) && !launch_en;
        pkt_drop   = valid_din && !ready_dout;
        pkt_uturn  = wr_en && (in_pkt.dx == COORD_W'(X_LOCAL)) && (in_pkt.dy == COORD_W'(Y_LOCAL));
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clka) begin
        if (rsta) begin
            error_dout <= 3'b000;
        end else begin
            error_dout <= error_dout | {pkt_uturn, pkt_drop, credit_ovf};
        end
    end
`else
    logic unused_cfg;

    // Checks are not built; coordinates and credit level are not needed.
    always_comb begin
        error_dout = 3'b000;
        unused_cfg = ^{COORD_W'(X_LOCAL), COORD_W'(Y_LOCAL), credit_cnt};
    end
`endif

endmodule

// File: tb/tb_outport.sv
// Scoreboard bench for outport: stimulus pushes expected link packets,
// a monitor pops and compares whenever the link strobe shows a valid packet.
module tb_outport;

    logic        clka;
    logic        rsta;
    logic        valid_din;
    logic [47:0] packet_din;
    logic        ready_dout;
    logic        credit_din;
    logic [1:0]  diff_pair_dout;
    logic [47:0] channel_dout;
    logic [2:0]  error_dout;

`ifdef OUTPORT_ERR_CHECK_EN
    localparam logic [2:0] ERR_MASK = 3'b111;
`else
    localparam logic [2:0] ERR_MASK = 3'b000;
`endif

    int vectors;
    int miscompares;
    logic [47:0] exp_q[$];

    outport #(
        .CREDITS (4),
        .X_LOCAL (2),
        .Y_LOCAL (2)
    ) dut (
        .clka           (clka),
        .rsta           (rsta),
        .valid_din      (valid_din),
        .packet_din     (packet_din),
        .ready_dout     (ready_dout),
        .credit_din     (credit_din),
        .diff_pair_dout (diff_pair_dout),
        .channel_dout   (channel_dout),
        .error_dout     (error_dout)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // Monitor: every valid strobe must carry the oldest outstanding packet.
    always @(negedge clka) begin
        if (!rsta) begin
            if (diff_pair_dout == 2'b10) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL link_unexpected: got %h, expected no packet at %0t", channel_dout, $time);
                end else begin
                    chk("link_data", channel_dout, exp_q.pop_front());
                end
            end else if (diff_pair_dout != 2'b00) begin
                chk("link_strobe_code", 48'(diff_pair_dout), 48'h0);
            end
        end
    end

    // Back-to-back writes; mask[i] is the expected strobe after edge i.
    task automatic burst(input int n, input int extra, input logic [47:0] base, input logic [15:0] mask);
        for (int i = 0; i < n + extra; i++) begin
            if (i < n) begin
                chk("burst_ready", 48'(ready_dout), 48'h1);
                valid_din  = 1'b1;
                packet_din = base + 48'(i);
                exp_q.push_back(base + 48'(i));
            end else begin
                valid_din = 1'b0;
            end
            step();
            chk("burst_strobe", 48'(diff_pair_dout), mask[i] ? 48'h2 : 48'h0);
        end
        valid_din = 1'b0;
    endtask

    // One credit return pulse, then the expected strobe after that edge.
    task automatic credit_pulse(input logic exp_launch);
        credit_din = 1'b1;
        step();
        credit_din = 1'b0;
        chk("credit_strobe", 48'(diff_pair_dout), exp_launch ? 48'h2 : 48'h0);
    endtask

    logic [1:0] pend;
    int         launches;
    int         guard;
    int         cyc;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rsta        = 1'b1;
        valid_din   = 1'b0;
        packet_din  = '0;
        credit_din  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ready", 48'(ready_dout), 48'h0);
        chk("rst_strobe", 48'(diff_pair_dout), 48'h0);
        chk("rst_channel", channel_dout, 48'h0);
        chk("rst_error", 48'(error_dout), 48'h0);
        rsta = 1'b0;
        #1;
        chk("ready_after_rst", 48'(ready_dout), 48'h1);

        // Single packet: visible one cycle after acceptance
        valid_din  = 1'b1;
        packet_din = 48'h2300_DEAD_BEEF;
        exp_q.push_back(48'h2300_DEAD_BEEF);
        step();
        valid_din = 1'b0;
        chk("single_no_bypass", 48'(diff_pair_dout), 48'h0);
        chk("single_ready", 48'(ready_dout), 48'h1);
        step();
        chk("single_strobe", 48'(diff_pair_dout), 48'h2);
        chk("single_channel", channel_dout, 48'h2300_DEAD_BEEF);
        step();
        chk("single_idle", 48'(diff_pair_dout), 48'h0);
        chk("single_hold", channel_dout, 48'h2300_DEAD_BEEF);
        credit_pulse(1'b0);

        // Five packets with four credits: P4 waits for a credit
        burst(5, 2, 48'h1100_0000_0100, 16'b0000_0000_0001_1110);
        credit_pulse(1'b0);
        step();
        chk("p4_after_credit", 48'(diff_pair_dout), 48'h2);

        // No credits: FIFO fills, ready drops, extra packet dropped
        burst(2, 0, 48'h3400_0000_0A00, 16'h0000);
        chk("full_ready", 48'(ready_dout), 48'h0);
        valid_din  = 1'b1;
        packet_din = 48'h3400_0000_0BAD;
        step();
        valid_din = 1'b0;
        chk("drop_strobe", 48'(diff_pair_dout), 48'h0);
        chk("drop_error", 48'(error_dout), 48'(3'b010 & ERR_MASK));

        // Credit return coinciding with a launch at credit_cnt = 1
        credit_din = 1'b1;
        step();
        chk("cr_first", 48'(diff_pair_dout), 48'h0);
        step();
        credit_din = 1'b0;
        chk("cr_same_cycle", 48'(diff_pair_dout), 48'h2);
        step();
        chk("cr_second_launch", 48'(diff_pair_dout), 48'h2);
        step();
        chk("cr_empty", 48'(diff_pair_dout), 48'h0);
        for (int i = 0; i < 4; i++) credit_pulse(1'b0);

        // Stream of 20 packets, credits returned two cycles after each launch
        pend     = 2'b00;
        launches = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    guard = 0;
                    while (!ready_dout && guard < 50) begin
                        step();
                        guard++;
                    end
                    if (!ready_dout) begin
                        chk("stream_ready_timeout", 48'(ready_dout), 48'h1);
                    end
                    valid_din  = 1'b1;
                    packet_din = 48'h5600_0000_0000 + 48'(i);
                    exp_q.push_back(48'h5600_0000_0000 + 48'(i));
                    step();
                    valid_din = 1'b0;
                end
            end
            begin
                cyc = 0;
                while (!(launches == 20 && pend == 2'b00) && cyc < 200) begin
                    step();
                    cyc++;
                    if (diff_pair_dout == 2'b10) launches++;
                    pend       = {pend[0], diff_pair_dout == 2'b10};
                    credit_din = pend[1];
                end
                credit_din = 1'b0;
            end
        join
        chk("stream_launches", 48'(launches), 48'd20);
        step();
        chk("stream_drained", 48'(exp_q.size()), 48'h0);
        chk("stream_error", 48'(error_dout), 48'(3'b010 & ERR_MASK));

        // Credit overflow while idle at full credit
        credit_pulse(1'b0);
        chk("ovf_error", 48'(error_dout), 48'(3'b011 & ERR_MASK));

        // U-turn packet to (2,2) is flagged but still launched
        valid_din  = 1'b1;
        packet_din = 48'h2200_1234_5678;
        exp_q.push_back(48'h2200_1234_5678);
        step();
        valid_din = 1'b0;
        chk("uturn_no_bypass", 48'(diff_pair_dout), 48'h0);
        step();
        chk("uturn_strobe", 48'(diff_pair_dout), 48'h2);
        chk("uturn_error", 48'(error_dout), 48'(3'b111 & ERR_MASK));

        // Saturated credits leave 3 after the U-turn launch: 3 go, 2 queue
        burst(5, 0, 48'h7800_0000_0C00, 16'b0000_0000_0000_1110);
        chk("pre_rst_ready", 48'(ready_dout), 48'h0);
        credit_pulse(1'b0);

        // Reset with 2 queued and credit_cnt = 1
        rsta = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_ready_during", 48'(ready_dout), 48'h0);
        step();
        chk("midrst_strobe", 48'(diff_pair_dout), 48'h0);
        chk("midrst_channel", channel_dout, 48'h0);
        chk("midrst_error", 48'(error_dout), 48'h0);
        chk("midrst_ready_held", 48'(ready_dout), 48'h0);
        rsta = 1'b0;
        #1;
        chk("midrst_ready_after", 48'(ready_dout), 48'h1);

        // Empty FIFO and four credits again after reset
        burst(5, 2, 48'h9A00_0000_0D00, 16'b0000_0000_0001_1110);
        credit_pulse(1'b0);
        step();
        chk("post_rst_last", 48'(diff_pair_dout), 48'h2);
        step();
        chk("final_drained", 48'(exp_q.size()), 48'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
